// File: rtl/change_dispenser_pkg.sv
// Shared types and coin constants for the change dispenser payout engine.
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_PULSE,
    ST_WAIT_ACK,
    ST_DONE
  } state_t;

  typedef enum logic {
    COIN_1,
    COIN_2
  } coin_t;

  localparam int COIN1_VAL = 1;
  localparam int COIN2_VAL = 2;

  function automatic int coin_value(input coin_t c);
    return (c == COIN_2) ? COIN2_VAL : COIN1_VAL;
  endfunction

endpackage

// File: rtl/change_dispenser_coin_inventory.sv
// One hopper's coin count: saturating refill, floor-at-zero eject, empty flag.
module coin_inventory #(
  parameter int W    = 8,
  parameter int INIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         empty
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Simultaneous refill and eject cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= W'(INIT);
    end else if (inc && !dec) begin
      if (count != CNT_MAX) count <= count + W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - W'(1);
    end
  end

  assign empty = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change/refund payout engine driving a value-2 and a value-1 coin hopper.
// Optional build macro HOPPER_TIMEOUT_EN adds a hopper-ack timeout with fault.
module change_dispenser #(
  parameter int AMT_W       = 3,
  parameter int INV_W       = 8,
  parameter int INV_INIT1   = 8,
  parameter int INV_INIT2   = 8,
  parameter int PULSE_CYC   = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill1,
  input  logic             refill2,
  input  logic             hop_ack,
  output logic             busy,
  output logic             hop1_pulse,
  output logic             hop2_pulse,
  output logic             done,
  output logic [AMT_W-1:0] short_amt,
  output logic             fault,
  output logic [INV_W-1:0] inv1,
  output logic [INV_W-1:0] inv2,
  output logic             empty1,
  output logic             empty2
);
  import change_dispenser_pkg::*;

  // state    | meaning
  // IDLE     | waiting for req, amount captured into rem
  // SEL      | pick value-2 coin, else value-1 coin, else finish
  // PULSE    | selected hopper pulse held PULSE_CYC cycles
  // WAIT_ACK | waiting for hopper ack (optionally bounded)
  // DONE     | one-cycle done strobe with unpaid remainder

  localparam int TMR_MAX = (ACK_TIMEOUT > PULSE_CYC) ? ACK_TIMEOUT : PULSE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t             state, next_state;
  coin_t              sel, next_sel;
  logic [AMT_W-1:0]   rem, next_rem;
  logic [TMR_W-1:0]   tmr, next_tmr;
  logic [AMT_W-1:0]   short_q, next_short;
  logic               fault_flag, next_fault_flag;
  logic               dec1, dec2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sel        <= COIN_1;
      rem        <= '0;
      tmr        <= '0;
      short_q    <= '0;
      fault_flag <= 1'b0;
    end else begin
      state      <= next_state;
      sel        <= next_sel;
      rem        <= next_rem;
      tmr        <= next_tmr;
      short_q    <= next_short;
      fault_flag <= next_fault_flag;
    end
  end

  always_comb begin
    next_state      = state;
    next_sel        = sel;
    next_rem        = rem;
    next_tmr        = tmr;
    next_short      = short_q;
    next_fault_flag = fault_flag;
    dec1            = 1'b0;
    dec2            = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          next_rem        = amount;
          next_fault_flag = 1'b0;
          next_state      = ST_SEL;
        end
      end
      ST_SEL: begin
        if (rem >= AMT_W'(COIN2_VAL) && !empty2) begin
          next_sel   = COIN_2;
          next_tmr   = TMR_W'(PULSE_CYC - 1);
          next_state = ST_PULSE;
        end else if (rem >= AMT_W'(COIN1_VAL) && !empty1) begin
          next_sel   = COIN_1;
          next_tmr   = TMR_W'(PULSE_CYC - 1);
          next_state = ST_PULSE;
        end else begin
          next_short = rem;
          next_state = ST_DONE;
        end
      end
      ST_PULSE: begin
        if (tmr == '0) begin
          next_tmr   = TMR_W'(ACK_TIMEOUT - 1);
          next_state = ST_WAIT_ACK;
        end else begin
          next_tmr = tmr - TMR_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        if (hop_ack) begin
          next_rem   = rem - AMT_W'(coin_value(sel));
          dec1       = (sel == COIN_1);
          dec2       = (sel == COIN_2);
          next_state = ST_SEL;
        end
`ifdef HOPPER_TIMEOUT_EN
        // Unacked coin is not charged to inventory; remainder reported as-is.
        else if (tmr == '0) begin
          next_short      = rem;
          next_fault_flag = 1'b1;
          next_state      = ST_DONE;
        end else begin
          next_tmr = tmr - TMR_W'(1);
        end
`endif
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign hop1_pulse = (state == ST_PULSE) && (sel == COIN_1);
  assign hop2_pulse = (state == ST_PULSE) && (sel == COIN_2);
  assign done       = (state == ST_DONE);
  assign short_amt  = short_q;
  assign fault      = (state == ST_DONE) && fault_flag;

  coin_inventory #(.W(INV_W), .INIT(INV_INIT1)) u_inv1 (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill1),
    .dec   (dec1),
    .count (inv1),
    .empty (empty1)
  );

  coin_inventory #(.W(INV_W), .INIT(INV_INIT2)) u_inv2 (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill2),
    .dec   (dec2),
    .count (inv2),
    .empty (empty2)
  );

endmodule
